// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV32I decode stage.
// Holds the opcode-class codes that drive imm_type/alu_op, the branch, memory-width and
// ALU source encodings, and the decoded control bundle.
// The bundle is produced by decode_logic and registered by decode_stage.
package decode_pkg;

  // Raw major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Opcode-class codes reuse the representative opcode of each class.
  // A value of 0 marks "no class" and appears on reset and on illegal instructions.
  localparam logic [6:0] CLS_R    = OPC_OP;
  localparam logic [6:0] CLS_I_OP = OPC_OP_IMM;
  localparam logic [6:0] CLS_I_LD = OPC_LOAD;
  localparam logic [6:0] CLS_U    = OPC_LUI;
  localparam logic [6:0] CLS_B    = OPC_BRANCH;
  localparam logic [6:0] CLS_J    = OPC_JAL;
  localparam logic [6:0] CLS_S    = OPC_STORE;

  localparam logic [3:0] BRANCH_OP_NEVER    = 4'b0000;
  localparam logic [3:0] BRANCH_OP_ZERO     = 4'b0101;
  localparam logic [3:0] BRANCH_OP_NON_ZERO = 4'b1010;
  localparam logic [3:0] BRANCH_OP_ALWAYS   = 4'b1111;

  localparam logic [3:0] MEM_WIDTH_WORD = 4'b0000;
  localparam logic [3:0] MEM_WIDTH_HALF = 4'b0101;
  localparam logic [3:0] MEM_WIDTH_BYTE = 4'b1010;

  localparam logic [3:0] SRC1_REG  = 4'b0000;
  localparam logic [3:0] SRC1_PC   = 4'b0101;
  localparam logic [3:0] SRC1_ZERO = 4'b1010;

  localparam logic [3:0] SRC2_REG  = 4'b0000;
  localparam logic [3:0] SRC2_IMM  = 4'b0101;
  localparam logic [3:0] SRC2_FOUR = 4'b1010;

  typedef struct packed {
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
    logic       rs1_read;
    logic       rs2_read;
    logic       rd_write;
    logic [6:0] imm_type;
    logic [6:0] alu_op;
    logic       alu_sub_sra;
    logic [3:0] alu_src1;
    logic [3:0] alu_src2;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_width;
    logic       mem_zero_extend;
    logic [3:0] branch_op;
    logic       illegal;
    logic       muldiv;
  } dec_bundle_t;

endpackage

// File: rtl/decode_logic.sv
// Purely combinational RV32I decoder: instruction word -> dec_bundle_t.
// Optional macro RV32M_EN adds the M-extension encodings (funct7 0000001 on OP).
// Without RV32M_EN those encodings are illegal and muldiv stays 0.
// Ports:
//   instr_i  in  32  instruction word
//   dec_o    out     decoded control bundle
module decode_logic
  import decode_pkg::*;
(
  input  logic [31:0]  instr_i,
  output dec_bundle_t  dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;
  dec_bundle_t d;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    d          = '0;
    illegal    = 1'b0;
    d.rs1_addr = instr_i[19:15];
    d.rs2_addr = instr_i[24:20];
    d.rd_addr  = instr_i[11:7];

    case (opcode)
      OPC_LUI: begin
        d.imm_type = CLS_U;
        d.alu_op   = CLS_U;
        d.alu_src1 = SRC1_ZERO;
        d.alu_src2 = SRC2_IMM;
        d.rd_write = 1'b1;
      end
      OPC_AUIPC: begin
        d.imm_type = CLS_U;
        d.alu_op   = CLS_U;
        d.alu_src1 = SRC1_PC;
        d.alu_src2 = SRC2_IMM;
        d.rd_write = 1'b1;
      end
      OPC_JAL: begin
        d.imm_type  = CLS_J;
        d.alu_op    = CLS_J;
        d.alu_src1  = SRC1_PC;
        d.alu_src2  = SRC2_FOUR;
        d.rd_write  = 1'b1;
        d.branch_op = BRANCH_OP_ALWAYS;
      end
      OPC_JALR: begin
        // ALU computes the link value pc+4; the target uses the I-immediate.
        d.imm_type  = CLS_I_OP;
        d.alu_op    = CLS_J;
        d.alu_src1  = SRC1_PC;
        d.alu_src2  = SRC2_FOUR;
        d.rs1_read  = 1'b1;
        d.rd_write  = 1'b1;
        d.branch_op = BRANCH_OP_ALWAYS;
        illegal     = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d.imm_type    = CLS_B;
        d.alu_op      = CLS_B;
        d.alu_sub_sra = 1'b1;
        d.rs1_read    = 1'b1;
        d.rs2_read    = 1'b1;
        case (funct3)
          3'b000, 3'b101, 3'b111: d.branch_op = BRANCH_OP_ZERO;
          3'b001, 3'b100, 3'b110: d.branch_op = BRANCH_OP_NON_ZERO;
          default:                illegal     = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d.imm_type = CLS_I_LD;
        d.alu_op   = CLS_I_LD;
        d.alu_src2 = SRC2_IMM;
        d.rs1_read = 1'b1;
        d.rd_write = 1'b1;
        d.mem_read = 1'b1;
        case (funct3)
          3'b000: d.mem_width = MEM_WIDTH_BYTE;
          3'b001: d.mem_width = MEM_WIDTH_HALF;
          3'b010: d.mem_width = MEM_WIDTH_WORD;
          3'b100: begin
            d.mem_width       = MEM_WIDTH_BYTE;
            d.mem_zero_extend = 1'b1;
          end
          3'b101: begin
            d.mem_width       = MEM_WIDTH_HALF;
            d.mem_zero_extend = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        d.imm_type  = CLS_S;
        d.alu_op    = CLS_S;
        d.alu_src2  = SRC2_IMM;
        d.rs1_read  = 1'b1;
        d.rs2_read  = 1'b1;
        d.mem_write = 1'b1;
        case (funct3)
          3'b000:  d.mem_width = MEM_WIDTH_BYTE;
          3'b001:  d.mem_width = MEM_WIDTH_HALF;
          3'b010:  d.mem_width = MEM_WIDTH_WORD;
          default: illegal     = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        d.imm_type = CLS_I_OP;
        d.alu_op   = CLS_I_OP;
        d.alu_src2 = SRC2_IMM;
        d.rs1_read = 1'b1;
        d.rd_write = 1'b1;
        case (funct3)
          3'b001: illegal = (funct7 != 7'b0000000);
          3'b010, 3'b011: d.alu_sub_sra = 1'b1;
          3'b101: begin
            if (funct7 == 7'b0100000) d.alu_sub_sra = 1'b1;
            else if (funct7 != 7'b0000000) illegal = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        d.imm_type = CLS_R;
        d.alu_op   = CLS_R;
        d.rs1_read = 1'b1;
        d.rs2_read = 1'b1;
        d.rd_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          d.alu_sub_sra = (funct3 == 3'b010) || (funct3 == 3'b011);
        end else if (funct7 == 7'b0100000) begin
          d.alu_sub_sra = 1'b1;
          illegal       = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
          d.muldiv = 1'b1;
`else
          illegal  = 1'b1;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      // FENCE and SYSTEM are not handled by this stage and are flagged.
      default: illegal = 1'b1;
    endcase

    dec_o = d;
    if (illegal) begin
      // Keep register indices for visibility; every side effect is suppressed.
      dec_o          = '0;
      dec_o.rs1_addr = d.rs1_addr;
      dec_o.rs2_addr = d.rs2_addr;
      dec_o.rd_addr  = d.rd_addr;
      dec_o.illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction FIFO, decoder on the FIFO head, registered output
// behind a valid/ready handshake, load-use interlock and flush.
// Optional macro RV32M_EN (see decode_logic) enables M-extension decoding.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   flush_in                           drop FIFO contents and output valid
//   instr_valid_in/instr_ready_out     fetch handshake, instr_in + pc_in payload
//   ex_load_in, ex_load_rd_in          load in EX and its destination register
//   dec_valid_out/dec_ready_in         execute handshake
//   pc_out ... muldiv_out              registered decode fields
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_in,
  input  logic            instr_valid_in,
  output logic            instr_ready_out,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            ex_load_in,
  input  logic [4:0]      ex_load_rd_in,
  output logic            dec_valid_out,
  input  logic            dec_ready_in,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1_addr_out,
  output logic [4:0]      rs2_addr_out,
  output logic [4:0]      rd_addr_out,
  output logic            rs1_read_out,
  output logic            rs2_read_out,
  output logic            rd_write_out,
  output logic [6:0]      imm_type_out,
  output logic [6:0]      alu_op_out,
  output logic            alu_sub_sra_out,
  output logic [3:0]      alu_src1_out,
  output logic [3:0]      alu_src2_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic [3:0]      mem_width_out,
  output logic            mem_zero_extend_out,
  output logic [3:0]      branch_op_out,
  output logic            illegal_out,
  output logic            muldiv_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      instr_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0]  pc_mem_q    [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  dec_bundle_t      bundle_q, bundle_d;
  logic [XLEN-1:0]  pc_q, pc_d;

  dec_bundle_t head_dec;
  logic        head_empty;
  logic        hazard;
  logic        push;
  logic        load;

  decode_logic u_decode_logic (
    .instr_i (instr_mem_q[rd_ptr_q]),
    .dec_o   (head_dec)
  );

  assign head_empty      = (count_q == '0);
  assign instr_ready_out = (count_q < CNT_W'(FIFO_DEPTH));
  assign push            = instr_valid_in && instr_ready_out && !flush_in;

  assign hazard = ex_load_in && (ex_load_rd_in != 5'd0) &&
                  ((head_dec.rs1_read && (head_dec.rs1_addr == ex_load_rd_in)) ||
                   (head_dec.rs2_read && (head_dec.rs2_addr == ex_load_rd_in)));

  assign load = !head_empty && !hazard && (!valid_q || dec_ready_in) && !flush_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(load);
    count_d  = count_q + CNT_W'(push) - CNT_W'(load);
    valid_d  = valid_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      bundle_d = head_dec;
      pc_d     = pc_mem_q[rd_ptr_q];
    end else if (dec_ready_in) begin
      // Register drained with nothing to replace it: bubble.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= instr_in;
      pc_mem_q[wr_ptr_q]    <= pc_in;
    end
  end

  assign dec_valid_out       = valid_q;
  assign pc_out              = pc_q;
  assign rs1_addr_out        = bundle_q.rs1_addr;
  assign rs2_addr_out        = bundle_q.rs2_addr;
  assign rd_addr_out         = bundle_q.rd_addr;
  assign rs1_read_out        = bundle_q.rs1_read;
  assign rs2_read_out        = bundle_q.rs2_read;
  assign rd_write_out        = bundle_q.rd_write;
  assign imm_type_out        = bundle_q.imm_type;
  assign alu_op_out          = bundle_q.alu_op;
  assign alu_sub_sra_out     = bundle_q.alu_sub_sra;
  assign alu_src1_out        = bundle_q.alu_src1;
  assign alu_src2_out        = bundle_q.alu_src2;
  assign mem_read_out        = bundle_q.mem_read;
  assign mem_write_out       = bundle_q.mem_write;
  assign mem_width_out       = bundle_q.mem_width;
  assign mem_zero_extend_out = bundle_q.mem_zero_extend;
  assign branch_op_out       = bundle_q.branch_op;
  assign illegal_out         = bundle_q.illegal;
  assign muldiv_out          = bundle_q.muldiv;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, FIFO_DEPTH=2). Expected values are
// hand-computed from the RV32I encodings; RV32M_EN selects the MUL expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        ex_load_in;
  logic [4:0]  ex_load_rd_in;
  logic        dec_valid_out;
  logic        dec_ready_in;
  logic [31:0] pc_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;
  logic        rs1_read_out, rs2_read_out, rd_write_out;
  logic [6:0]  imm_type_out, alu_op_out;
  logic        alu_sub_sra_out;
  logic [3:0]  alu_src1_out, alu_src2_out;
  logic        mem_read_out, mem_write_out;
  logic [3:0]  mem_width_out;
  logic        mem_zero_extend_out;
  logic [3:0]  branch_op_out;
  logic        illegal_out, muldiv_out;

  int checks = 0;
  int errors = 0;

`ifdef RV32M_EN
  localparam logic MUL_OK = 1'b1;
`else
  localparam logic MUL_OK = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_in            (flush_in),
    .instr_valid_in      (instr_valid_in),
    .instr_ready_out     (instr_ready_out),
    .instr_in            (instr_in),
    .pc_in               (pc_in),
    .ex_load_in          (ex_load_in),
    .ex_load_rd_in       (ex_load_rd_in),
    .dec_valid_out       (dec_valid_out),
    .dec_ready_in        (dec_ready_in),
    .pc_out              (pc_out),
    .rs1_addr_out        (rs1_addr_out),
    .rs2_addr_out        (rs2_addr_out),
    .rd_addr_out         (rd_addr_out),
    .rs1_read_out        (rs1_read_out),
    .rs2_read_out        (rs2_read_out),
    .rd_write_out        (rd_write_out),
    .imm_type_out        (imm_type_out),
    .alu_op_out          (alu_op_out),
    .alu_sub_sra_out     (alu_sub_sra_out),
    .alu_src1_out        (alu_src1_out),
    .alu_src2_out        (alu_src2_out),
    .mem_read_out        (mem_read_out),
    .mem_write_out       (mem_write_out),
    .mem_width_out       (mem_width_out),
    .mem_zero_extend_out (mem_zero_extend_out),
    .branch_op_out       (branch_op_out),
    .illegal_out         (illegal_out),
    .muldiv_out          (muldiv_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    instr_valid_in = 1'b1;
    instr_in       = instr;
    pc_in          = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush_in = 1'b0; instr_valid_in = 1'b0; instr_in = '0; pc_in = '0;
    ex_load_in = 1'b0; ex_load_rd_in = '0; dec_ready_in = 1'b0;
    step(); step();
    check("rst_valid", 32'(dec_valid_out), 32'h0);
    check("rst_ready", 32'(instr_ready_out), 32'h1);
    check("rst_pc", pc_out, 32'h0);
    check("rst_branch", 32'(branch_op_out), 32'h0);
    check("rst_width", 32'(mem_width_out), 32'h0);
    #3 rst_n = 1'b1;
    step();

    // ADDI x1,x0,5: visible after the second edge
    dec_ready_in = 1'b1;
    offer(32'h00500093, 32'h100);
    step(); instr_valid_in = 1'b0;
    check("addi_lat1", 32'(dec_valid_out), 32'h0);
    step();
    check("addi_valid", 32'(dec_valid_out), 32'h1);
    check("addi_rd", 32'(rd_addr_out), 32'd1);
    check("addi_src2", 32'(alu_src2_out), 32'b0101);
    check("addi_rdw", 32'(rd_write_out), 32'h1);
    check("addi_ill", 32'(illegal_out), 32'h0);
    check("addi_pc", pc_out, 32'h100);
    check("addi_aluop", 32'(alu_op_out), 32'b0010011);
    step();
    check("addi_drain", 32'(dec_valid_out), 32'h0);

    // Backpressure: three pushes with dec_ready low
    dec_ready_in = 1'b0;
    offer(32'h002081B3, 32'h200);           // ADD x3,x1,x2
    step();
    offer(32'h40208233, 32'h204);           // SUB x4,x1,x2
    step();
    check("bp_ready2", 32'(instr_ready_out), 32'h1);
    offer(32'h00700293, 32'h208);           // ADDI x5,x0,7
    step(); instr_valid_in = 1'b0;
    check("bp_ready3", 32'(instr_ready_out), 32'h0);
    check("bp_valid", 32'(dec_valid_out), 32'h1);
    check("bp_pcA", pc_out, 32'h200);
    step();
    check("bp_stableA", pc_out, 32'h200);
    check("bp_stable_rd", 32'(rd_addr_out), 32'd3);
    check("bp_ready_full", 32'(instr_ready_out), 32'h0);
    dec_ready_in = 1'b1;
    step();
    check("bp_pcB", pc_out, 32'h204);
    check("bp_subB", 32'(alu_sub_sra_out), 32'h1);
    check("bp_ready_after_pop", 32'(instr_ready_out), 32'h1);
    step();
    check("bp_pcC", pc_out, 32'h208);
    check("bp_rdC", 32'(rd_addr_out), 32'd5);
    check("bp_validC", 32'(dec_valid_out), 32'h1);
    step();
    check("bp_drain", 32'(dec_valid_out), 32'h0);

    // Load-use hazard on rs1 = x5
    ex_load_in = 1'b1; ex_load_rd_in = 5'd5;
    offer(32'h006281B3, 32'h300);           // ADD x3,x5,x6
    step(); instr_valid_in = 1'b0;
    step();
    check("hz_bubble1", 32'(dec_valid_out), 32'h0);
    step();
    check("hz_bubble2", 32'(dec_valid_out), 32'h0);
    ex_load_in = 1'b0;
    step();
    check("hz_issue", 32'(dec_valid_out), 32'h1);
    check("hz_pc", pc_out, 32'h300);
    check("hz_rs1", 32'(rs1_addr_out), 32'd5);
    step();
    ex_load_in = 1'b1; ex_load_rd_in = 5'd0;
    offer(32'h006281B3, 32'h304);
    step(); instr_valid_in = 1'b0;
    step();
    check("hz_x0_nostall", 32'(dec_valid_out), 32'h1);
    check("hz_x0_pc", pc_out, 32'h304);
    ex_load_in = 1'b0;
    step();

    // Flush with one instruction in the register and one in the FIFO
    dec_ready_in = 1'b0;
    offer(32'h00500093, 32'h400);
    step();
    offer(32'h00500093, 32'h404);
    step();
    check("fl_pre_valid", 32'(dec_valid_out), 32'h1);
    flush_in = 1'b1;
    offer(32'h00500093, 32'h40C);
    step();
    flush_in = 1'b0; instr_valid_in = 1'b0; dec_ready_in = 1'b1;
    check("fl_valid", 32'(dec_valid_out), 32'h0);
    check("fl_ready", 32'(instr_ready_out), 32'h1);
    step();
    check("fl_none1", 32'(dec_valid_out), 32'h0);
    step();
    check("fl_none2", 32'(dec_valid_out), 32'h0);

    // Illegal, MUL, LBU, BNE streamed back to back
    offer(32'hFFFFFFFF, 32'h500);
    step();
    offer(32'h023100B3, 32'h504);
    step();
    check("ill_valid", 32'(dec_valid_out), 32'h1);
    check("ill_flag", 32'(illegal_out), 32'h1);
    check("ill_rdw", 32'(rd_write_out), 32'h0);
    check("ill_rs1r", 32'(rs1_read_out), 32'h0);
    check("ill_memr", 32'(mem_read_out), 32'h0);
    check("ill_branch", 32'(branch_op_out), 32'h0);
    offer(32'h0000C383, 32'h508);
    step();
    check("mul_pc", pc_out, 32'h504);
    check("mul_valid", 32'(dec_valid_out), 32'h1);
    check("mul_illegal", 32'(illegal_out), 32'(!MUL_OK));
    check("mul_muldiv", 32'(muldiv_out), 32'(MUL_OK));
    check("mul_rdw", 32'(rd_write_out), 32'(MUL_OK));
    offer(32'h00209463, 32'h50C);
    step(); instr_valid_in = 1'b0;
    check("lbu_pc", pc_out, 32'h508);
    check("lbu_memr", 32'(mem_read_out), 32'h1);
    check("lbu_width", 32'(mem_width_out), 32'b1010);
    check("lbu_zext", 32'(mem_zero_extend_out), 32'h1);
    step();
    check("bne_pc", pc_out, 32'h50C);
    check("bne_op", 32'(branch_op_out), 32'b1010);
    check("bne_sub", 32'(alu_sub_sra_out), 32'h1);
    check("bne_rdw", 32'(rd_write_out), 32'h0);
    step();
    check("stream_drain", 32'(dec_valid_out), 32'h0);

    // Asynchronous reset while streaming
    offer(32'h00500093, 32'h600);
    step();
    offer(32'h00500093, 32'h604);
    step(); instr_valid_in = 1'b0;
    check("ar_pre_valid", 32'(dec_valid_out), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(dec_valid_out), 32'h0);
    check("ar_pc", pc_out, 32'h0);
    check("ar_rdw", 32'(rd_write_out), 32'h0);
    check("ar_ready", 32'(instr_ready_out), 32'h1);
    #2 rst_n = 1'b1;
    step();
    check("ar_nothing", 32'(dec_valid_out), 32'h0);
    offer(32'h00500093, 32'h700);
    step(); instr_valid_in = 1'b0;
    check("ar_lat1", 32'(dec_valid_out), 32'h0);
    step();
    check("ar_valid2", 32'(dec_valid_out), 32'h1);
    check("ar_pc2", pc_out, 32'h700);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
